mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative signed multiply/divide engine with its own sequencing FSM. It owns the HI/LO registers and services the MIPS `mult`, `div`, `mfhi` and `mflo` instructions. It sits beside the main ALU in the multicycle datapath. The main control FSM starts an operation, waits on `busy`/`done`, and branches to its divide-by-zero exception state on `div_zero`.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `start_mult`  in  1  request signed multiply of `a`×`b`; sampled only in IDLE
- `start_div`  in  1  request signed divide `a`÷`b`; sampled only in IDLE
- `a`  in  32  operand A (multiplicand / dividend), latched at start
- `b`  in  32  operand B (multiplier / divisor), latched at start
- `hi`  out  32  HI register: product[63:32] or remainder
- `lo`  out  32  LO register: product[31:0] or quotient
- `busy`  out  1  high while an operation is in progress
- `done`  out  1  one-cycle pulse when HI/LO have been updated or a divide by zero has been detected
- `div_zero`  out  1  one-cycle pulse, coincident with `done`, when the divisor is 0

## Operation
- FSM states: IDLE, MULT, DIV, FINISH, DZERO. Iteration counter is 6 bits.
- IDLE:
  - `start_mult`=1 → latch `a`, `b`, clear the Booth accumulator, counter=0, go to MULT.
  - Otherwise `start_div`=1 → latch `a`, `b`; if `b`==0 go to DZERO, else go to DIV.
  - If both starts are high, the multiply wins and the divide request is dropped.
- MULT: radix-2 Booth, one step per cycle over {acc[32:0], Q, q₋₁}: add/subtract M according to (Q[0], q₋₁), then arithmetic shift right. After 32 steps go to FINISH.
- DIV: restoring division on operand magnitudes, one quotient bit per cycle, 32 steps, then go to FINISH.
- FINISH:
  - Multiply: {hi, lo} ← 64-bit signed product.
  - Divide: lo ← quotient truncated toward zero (negated if the operand signs differ); hi ← remainder carrying the sign of the dividend.
  - Pulse `done`, return to IDLE.
- DZERO: pulse `done` and `div_zero`, leave HI/LO unchanged, return to IDLE.
- Arithmetic rules:
  - Absolute value of 0x80000000 is handled as a 33-bit magnitude.
  - 0x80000000 ÷ −1 gives lo=0x80000000, hi=0, with no flag.
- A start asserted while `busy`=1 is ignored. It is not queued.
- HI/LO hold their value between operations and are read combinationally at any time.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, div_zero=0, state=IDLE, counter=0.
- Start sampled at edge k (state IDLE):
  - `busy`=1 from edge k onward.
  - Iteration steps occur on edges k+1 … k+32.
  - On edge k+33: HI/LO are written, `done`=1, `busy`=0.
  - Latency is 33 cycles from the start edge to `done`.
- Divide by zero: `busy`=1 after edge k; at edge k+1 `done`=`div_zero`=1 and `busy`=0. Latency is 1 cycle.
- `done` and `div_zero` are high for exactly one cycle.
- A new start can be sampled in the same cycle `done` is high, since the state is already IDLE.
- Reset mid-operation aborts the operation on the next edge:
  - All outputs return to their reset values, including clearing HI/LO.
  - No `done` pulse is produced.
- The main control must hold operands stable only at the start edge; `a`/`b` are don't-care afterwards.

## Test plan
- Multiply 7 × −3 (b=0xFFFFFFFD) → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB, one-cycle `done`, `busy` low.
- Divide −7 ÷ 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Divide 7 ÷ −2 → lo=0xFFFFFFFD, hi=0x00000001. Both with 33-cycle latency.
- Divide 100 ÷ 0 with HI/LO preloaded to 5/9 → `done`=`div_zero`=1 one cycle after start, hi=5, lo=9 unchanged.
- Corner operands:
  - 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0.
  - 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- `start_div` pulsed at cycle 10 of a running multiply → ignored; the multiply result is correct and only one `done` occurs. Both starts high together → multiply performed.
- Reset asserted at cycle 15 of a divide → next cycle hi=lo=0, busy=0, no `done`. A fresh multiply 3 × 4 then gives hi=0, lo=12.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply/divide engine owning the HI/LO
// registers for the MIPS mult, div, mfhi and mflo instructions.
//
// Ports:
//   clk        system clock, every state update happens on the rising edge
//   reset      synchronous, active-high; clears all state including HI/LO
//   start_mult request signed a*b (sampled only while idle; wins over div)
//   start_div  request signed a/b (sampled only while idle)
//   a, b       operands, latched on the start edge only
//   hi, lo     HI/LO registers: product[63:32]/[31:0] or remainder/quotient
//   busy       high while an operation is in flight
//   done       one-cycle pulse when HI/LO are updated or a divide by zero is seen
//   div_zero   one-cycle pulse alongside done when the divisor was zero
//
// state  | meaning
// IDLE   | waiting for a start request
// MULT   | one radix-2 Booth step per cycle
// DIV    | one restoring-division quotient bit per cycle
// FINISH | sign-correct the result, write HI/LO, pulse done
// DZERO  | divisor was zero: pulse done and div_zero, HI/LO untouched
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [2:0] {IDLE, MULT, DIV, FINISH, DZERO} state_t;

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    state_t           state, next_state;
    logic [5:0]       cnt;
    // acc is one bit wider than the operands so Booth can add/subtract
    // -2^(WIDTH-1) without overflow; during divide it holds the remainder.
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   m;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic             op_div;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH:0]   abs_b;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_trial;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_mult)     next_state = MULT;
                else if (start_div) next_state = (b == '0) ? DZERO : DIV;
            end
            MULT, DIV: if (cnt == LAST_STEP) next_state = FINISH;
            FINISH, DZERO: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_comb begin
        // -0x80000000 wraps to 0x80000000, which read unsigned is the
        // correct magnitude 2^(WIDTH-1); the divisor is kept one bit wider.
        abs_a     = a[WIDTH-1] ? -a : a;
        abs_b     = b[WIDTH-1] ? -{b[WIDTH-1], b} : {b[WIDTH-1], b};
        booth_sum = acc;
        case ({q[0], q_m1})
            2'b01:   booth_sum = acc + m;
            2'b10:   booth_sum = acc - m;
            default: booth_sum = acc;
        endcase
        div_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {1'b0, m};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            m        <= '0;
            q        <= '0;
            q_m1     <= 1'b0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_mult) begin
                        m      <= {a[WIDTH-1], a};
                        q      <= b;
                        acc    <= '0;
                        q_m1   <= 1'b0;
                        cnt    <= '0;
                        op_div <= 1'b0;
                    end else if (start_div) begin
                        m      <= abs_b;
                        q      <= abs_a;
                        acc    <= '0;
                        q_m1   <= 1'b0;
                        cnt    <= '0;
                        op_div <= 1'b1;
                        neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                        neg_r  <= a[WIDTH-1];
                    end
                end
                MULT: begin
                    acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    q    <= {booth_sum[0], q[WIDTH-1:1]};
                    q_m1 <= q[0];
                    cnt  <= cnt + 6'd1;
                end
                DIV: begin
                    // Trial subtraction goes negative -> restore (keep shift).
                    if (!div_trial[WIDTH+1]) begin
                        acc <= div_trial[WIDTH:0];
                        q   <= {q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= div_shift;
                        q   <= {q[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 6'd1;
                end
                FINISH: begin
                    if (op_div) begin
                        lo <= neg_q ? -q : q;
                        hi <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                    end else begin
                        hi <= acc[WIDTH-1:0];
                        lo <= q;
                    end
                    done <= 1'b1;
                end
                DZERO: begin
                    done     <= 1'b1;
                    div_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    typedef struct packed {
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    exp_t        sb[$];
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
        .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: computes the expected HI/LO with native 64-bit math.
    task automatic push_expected(input bit is_div, input logic [31:0] oa, input logic [31:0] ob);
        exp_t   e;
        longint la, lb, p, qq, rr;
        la = longint'($signed(oa));
        lb = longint'($signed(ob));
        if (is_div && ob == 32'd0) begin
            e = {hi_m, lo_m, 1'b1};
        end else if (is_div) begin
            qq = la / lb;
            rr = la % lb;
            hi_m = rr[31:0];
            lo_m = qq[31:0];
            e = {hi_m, lo_m, 1'b0};
        end else begin
            p = la * lb;
            hi_m = p[63:32];
            lo_m = p[31:0];
            e = {hi_m, lo_m, 1'b0};
        end
        sb.push_back(e);
    endtask

    // Issues one operation and observes it; makes no judgement itself.
    task automatic run_op(input bit is_div, input logic [31:0] oa, input logic [31:0] ob,
                          input bit both, output int lat, output logic [31:0] ohi,
                          output logic [31:0] olo, output logic odz, output logic obusy0,
                          output logic obusy_done, output logic odone_next);
        lat = -1; ohi = '0; olo = '0; odz = 1'b0; obusy_done = 1'b1; odone_next = 1'b0;
        @(negedge clk);
        start_mult = !is_div;
        start_div  = is_div || both;
        a = oa;
        b = ob;
        push_expected(is_div, oa, ob);
        @(posedge clk); #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a = $urandom;
        b = $urandom;
        obusy0 = busy;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i; ohi = hi; olo = lo; odz = div_zero; obusy_done = busy;
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clk); #1;
            odone_next = done;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({hi, lo, busy, done, div_zero} !== 67'd0) begin
            bad++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b dz=%b want all zero",
                     hi, lo, busy, done, div_zero);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_ops();
        op_t         tbl[$];
        exp_t        e;
        int          lat, want_lat;
        logic [31:0] ohi, olo;
        logic        odz, ob0, obd, odn;
        tbl.push_back({1'b0, 32'd7, 32'hFFFF_FFFD});
        tbl.push_back({1'b1, 32'hFFFF_FFF9, 32'd2});
        tbl.push_back({1'b1, 32'd7, 32'hFFFF_FFFE});
        tbl.push_back({1'b1, 32'h8000_0000, 32'hFFFF_FFFF});
        tbl.push_back({1'b0, 32'h8000_0000, 32'h8000_0000});
        tbl.push_back({1'b0, 32'h7FFF_FFFF, 32'h8000_0000});
        tbl.push_back({1'b1, 32'h8000_0000, 32'd3});
        tbl.push_back({1'b1, 32'd5, 32'd9});
        for (int i = 0; i < 6; i++)
            tbl.push_back({1'(i % 2), 32'($urandom), 32'($urandom_range(1, 32'hFFFF_FFFF))});
        foreach (tbl[i]) begin
            run_op(tbl[i].d, tbl[i].a, tbl[i].b, 1'b0, lat, ohi, olo, odz, ob0, obd, odn);
            e = sb.pop_front();
            want_lat = e.dz ? 1 : 33;
            total++;
            if (lat !== want_lat) begin
                bad++;
                $display("FAIL op%0d latency: got %0d want %0d", i, lat, want_lat);
            end
            total++;
            if ({ohi, olo, odz} !== e) begin
                bad++;
                $display("FAIL op%0d result: got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                         i, ohi, olo, odz, e.hi, e.lo, e.dz);
            end
            total++;
            if ({ob0, obd, odn} !== 3'b100) begin
                bad++;
                $display("FAIL op%0d busy/done shape: got busy_start=%b busy_done=%b done_next=%b want 1 0 0",
                         i, ob0, obd, odn);
            end
        end
    endtask

    task automatic test_div_zero();
        exp_t        e;
        int          lat;
        logic [31:0] ohi, olo;
        logic        odz, ob0, obd, odn;
        run_op(1'b1, 32'd59, 32'd6, 1'b0, lat, ohi, olo, odz, ob0, obd, odn);
        e = sb.pop_front();
        total++;
        if ({ohi, olo} !== {e.hi, e.lo}) begin
            bad++;
            $display("FAIL dz_preload: got hi=%h lo=%h want hi=%h lo=%h", ohi, olo, e.hi, e.lo);
        end
        run_op(1'b1, 32'd100, 32'd0, 1'b0, lat, ohi, olo, odz, ob0, obd, odn);
        e = sb.pop_front();
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL dz_latency: got %0d want 1", lat);
        end
        total++;
        if ({ohi, olo, odz} !== e) begin
            bad++;
            $display("FAIL dz_result: got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                     ohi, olo, odz, e.hi, e.lo, e.dz);
        end
        total++;
        if ({ob0, obd, odn} !== 3'b100) begin
            bad++;
            $display("FAIL dz_busy_done: got busy_start=%b busy_done=%b done_next=%b want 1 0 0",
                     ob0, obd, odn);
        end
    endtask

    task automatic test_start_while_busy();
        exp_t        e;
        int          lat, done_cnt;
        logic [31:0] ohi, olo;
        lat = -1; done_cnt = 0; ohi = '0; olo = '0;
        @(negedge clk);
        start_mult = 1'b1; a = 32'd12345; b = 32'hFFFF_FD4A;
        push_expected(1'b0, a, b);
        @(posedge clk); #1;
        start_mult = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            start_div = (i == 9);
            if (i == 9) begin a = 32'd1; b = 32'd0; end
            if (done) begin
                done_cnt++;
                if (lat < 0) begin lat = i; ohi = hi; olo = lo; end
            end
        end
        start_div = 1'b0;
        e = sb.pop_front();
        total++;
        if (done_cnt !== 1 || lat !== 33) begin
            bad++;
            $display("FAIL busy_ignore_done: got count=%0d latency=%0d want count=1 latency=33",
                     done_cnt, lat);
        end
        total++;
        if ({ohi, olo} !== {e.hi, e.lo}) begin
            bad++;
            $display("FAIL busy_ignore_result: got hi=%h lo=%h want hi=%h lo=%h",
                     ohi, olo, e.hi, e.lo);
        end
    endtask

    task automatic test_both_starts();
        exp_t        e;
        int          lat;
        logic [31:0] ohi, olo;
        logic        odz, ob0, obd, odn;
        run_op(1'b0, 32'd5, 32'd0, 1'b1, lat, ohi, olo, odz, ob0, obd, odn);
        e = sb.pop_front();
        total++;
        if (lat !== 33 || {ohi, olo, odz} !== e) begin
            bad++;
            $display("FAIL both_starts: got lat=%0d hi=%h lo=%h dz=%b want lat=33 hi=%h lo=%h dz=%b",
                     lat, ohi, olo, odz, e.hi, e.lo, e.dz);
        end
    endtask

    task automatic test_reset_mid_op();
        exp_t        e;
        int          lat, done_cnt;
        logic [31:0] ohi, olo;
        logic        odz, ob0, obd, odn;
        run_op(1'b0, 32'd1234, 32'd5678, 1'b0, lat, ohi, olo, odz, ob0, obd, odn);
        void'(sb.pop_front());
        @(negedge clk);
        start_div = 1'b1; a = 32'hFFFF_FC18; b = 32'd7;
        push_expected(1'b1, a, b);
        @(posedge clk); #1;
        start_div = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({hi, lo, busy, done, div_zero} !== 67'd0) begin
            bad++;
            $display("FAIL reset_mid_op: got hi=%h lo=%h busy=%b done=%b dz=%b want all zero",
                     hi, lo, busy, done, div_zero);
        end
        reset = 1'b0;
        sb.delete();
        hi_m = '0;
        lo_m = '0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        total++;
        if (done_cnt !== 0) begin
            bad++;
            $display("FAIL reset_no_done: got %0d done pulses want 0", done_cnt);
        end
        run_op(1'b0, 32'd3, 32'd4, 1'b0, lat, ohi, olo, odz, ob0, obd, odn);
        e = sb.pop_front();
        total++;
        if (lat !== 33 || {ohi, olo, odz} !== e) begin
            bad++;
            $display("FAIL after_reset_mult: got lat=%0d hi=%h lo=%h want lat=33 hi=%h lo=%h",
                     lat, ohi, olo, e.hi, e.lo);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int          lat1, lat2;
        logic [31:0] h1, l1, h2, l2;
        logic        busy_new;
        lat1 = -1; lat2 = -1; h1 = '0; l1 = '0; h2 = '0; l2 = '0; busy_new = 1'b0;
        @(negedge clk);
        start_mult = 1'b1; a = 32'hFFFF_FFF7; b = 32'd11;
        push_expected(1'b0, a, b);
        @(posedge clk); #1;
        start_mult = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin lat1 = i; h1 = hi; l1 = lo; break; end
        end
        // Issue the next divide in the very cycle done is high.
        start_div = 1'b1; a = 32'd1000; b = 32'hFFFF_FFDF;
        push_expected(1'b1, a, b);
        @(posedge clk); #1;
        start_div = 1'b0;
        busy_new = busy;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin lat2 = i; h2 = hi; l2 = lo; break; end
        end
        e = sb.pop_front();
        total++;
        if (lat1 !== 33 || {h1, l1} !== {e.hi, e.lo}) begin
            bad++;
            $display("FAIL b2b_first: got lat=%0d hi=%h lo=%h want lat=33 hi=%h lo=%h",
                     lat1, h1, l1, e.hi, e.lo);
        end
        e = sb.pop_front();
        total++;
        if (busy_new !== 1'b1 || lat2 !== 33 || {h2, l2} !== {e.hi, e.lo}) begin
            bad++;
            $display("FAIL b2b_second: got busy=%b lat=%0d hi=%h lo=%h want busy=1 lat=33 hi=%h lo=%h",
                     busy_new, lat2, h2, l2, e.hi, e.lo);
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_div_zero();
        test_start_while_busy();
        test_both_starts();
        test_reset_mid_op();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
